// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the comma-aligning deserializer and the comma
// detector:
//   - lock_state_e : symbol-lock FSM encoding (UNLOCKED / ALIGNED / LOCKED)
//   - K28_5_RDN/RDP: K28.5 comma patterns, first-received bit in bit 0
//   - CNT_W        : width of the ok/err alignment counters
//   - sat_add8     : saturating 8-bit accumulate for the error counter
// -----------------------------------------------------------------------------
package deser_pkg;

  localparam int CNT_W = 4;

  localparam logic [9:0] K28_5_RDN = 10'b0101111100;
  localparam logic [9:0] K28_5_RDP = 10'b1010000011;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNED  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  // Add a small increment to an 8-bit count, sticking at 8'hFF.
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'b0000000, inc};
    if (sum[8]) begin
      return 8'hFF;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/comma_align_deserializer_comma_detect.sv
// -----------------------------------------------------------------------------
// comma_detect
// Purely combinational pattern matcher: flags when a word equals either of two
// reference patterns. Kept separate so the parallel-path aligner can reuse it.
// Ports:
//   word_i      : candidate word
//   pattern_a_i : first reference pattern (e.g. K28.5 RD-)
//   pattern_b_i : second reference pattern (e.g. K28.5 RD+)
//   match_o     : 1 when word_i equals either pattern
// -----------------------------------------------------------------------------
module comma_detect #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [WIDTH-1:0] pattern_a_i,
  input  logic [WIDTH-1:0] pattern_b_i,
  output logic             match_o
);

  assign match_o = (word_i == pattern_a_i) | (word_i == pattern_b_i);

endmodule

// File: rtl/comma_align_deserializer.sv
// -----------------------------------------------------------------------------
// comma_align_deserializer
// Serial-to-parallel converter between the CDR and the 8b/10b decoder. Bits
// are shifted in LSB-first (optionally inverted), one word is emitted every
// DATA_WIDTH bits, and K28.5 commas are used to fix the word boundary under
// control of a symbol-lock state machine.
// Ports:
//   Recovered_Bit_Clk : recovered bit clock, rising edge
//   Rst_n             : asynchronous active-low reset
//   Ser_in            : recovered serial bit
//   RxPolarity        : 1 = invert Ser_in before shifting
//   Align_En          : 1 = comma realignment allowed
//   Data_Collected    : last complete word
//   Data_Valid        : one-cycle pulse when Data_Collected updates
//   Comma_Det         : qualifies Data_Valid, emitted word is a comma
//   Symbol_Lock       : high in LOCKED
//   Realign           : one-cycle pulse when the word boundary moves
//   Err_Cnt           : (only with DESER_ERR_CNT_EN) saturating count of
//                       misaligned commas in LOCKED plus lock losses
// Optional build macro: DESER_ERR_CNT_EN adds the Err_Cnt port and counter.
// -----------------------------------------------------------------------------
module comma_align_deserializer
  import deser_pkg::*;
#(
  parameter int         DATA_WIDTH = 10,
  parameter logic [9:0] COMMA_RDN  = K28_5_RDN,
  parameter logic [9:0] COMMA_RDP  = K28_5_RDP,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 4
) (
  input  logic                  Recovered_Bit_Clk,
  input  logic                  Rst_n,
  input  logic                  Ser_in,
  input  logic                  RxPolarity,
  input  logic                  Align_En,
  output logic [DATA_WIDTH-1:0] Data_Collected,
  output logic                  Data_Valid,
  output logic                  Comma_Det,
  output logic                  Symbol_Lock,
  output logic                  Realign
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [7:0]            Err_Cnt
`endif
);

  localparam int               BC_W        = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0]  LAST_BIT    = BC_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LOCK_CNT_C  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] LOSS_CNT_C  = CNT_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

  // Registered state
  logic [DATA_WIDTH-1:0] sr_q;
  logic [BC_W-1:0]       bit_cnt_q;
  logic [CNT_W-1:0]      ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
  lock_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;
  logic                  comma_det_q;
  logic                  symbol_lock_q;
  logic                  realign_q;

  // Combinational helpers
  logic                  serial_s;
  logic [DATA_WIDTH-1:0] sr_next_s;
  logic                  boundary_s;
  logic                  comma_match_s;
  logic                  aligned_comma_s;
  logic                  misaligned_comma_s;
  logic                  realign_s;
  logic                  emit_s;
  logic [CNT_W-1:0]      ok_inc_s;
  logic [CNT_W-1:0]      err_inc_s;

  assign serial_s           = RxPolarity ? ~Ser_in : Ser_in;
  assign sr_next_s          = {serial_s, sr_q[DATA_WIDTH-1:1]};
  assign boundary_s         = (bit_cnt_q == LAST_BIT);
  assign aligned_comma_s    = comma_match_s & boundary_s;
  assign misaligned_comma_s = comma_match_s & ~boundary_s;
  assign ok_inc_s           = ok_cnt_q + CNT_ONE;
  assign err_inc_s          = err_cnt_q + CNT_ONE;
  // A realign emits on its own edge; when it coincides with a boundary the
  // two collapse into a single emission.
  assign emit_s             = boundary_s | realign_s;

  // Comma patterns only make sense for 10-bit symbols; other widths never match.
  generate
    if (DATA_WIDTH == 10) begin : g_comma_match
      comma_detect #(
        .WIDTH (DATA_WIDTH)
      ) u_comma_detect (
        .word_i      (sr_next_s),
        .pattern_a_i (COMMA_RDN),
        .pattern_b_i (COMMA_RDP),
        .match_o     (comma_match_s)
      );
    end else begin : g_no_comma_match
      assign comma_match_s = 1'b0;
    end
  endgenerate

  // Symbol-lock FSM state and alignment counters register.
  always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= UNLOCKED;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Symbol-lock next-state logic and realign decision.
  always_comb begin
    state_d   = state_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    realign_s = 1'b0;

    case (state_q)
      UNLOCKED: begin
        if (comma_match_s && Align_En) begin
          realign_s = 1'b1;
        end else begin
          realign_s = 1'b0;
        end
      end

      ALIGNED: begin
        // Intervening data words leave ok_cnt untouched.
        if (aligned_comma_s) begin
          ok_cnt_d = ok_inc_s;
          if (ok_inc_s >= LOCK_CNT_C) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
          end else begin
            state_d   = ALIGNED;
          end
        end else if (misaligned_comma_s && Align_En) begin
          realign_s = 1'b1;
        end else begin
          realign_s = 1'b0;
        end
      end

      LOCKED: begin
        // Boundary is frozen here whatever Align_En says.
        if (aligned_comma_s) begin
          err_cnt_d = '0;
        end else if (misaligned_comma_s) begin
          if (err_inc_s >= LOSS_CNT_C) begin
            // Drop lock but keep the current boundary.
            state_d   = UNLOCKED;
            ok_cnt_d  = '0;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_inc_s;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end

      default: begin
        state_d   = UNLOCKED;
        ok_cnt_d  = '0;
        err_cnt_d = '0;
      end
    endcase

    if (realign_s) begin
      ok_cnt_d  = CNT_ONE;
      err_cnt_d = '0;
      if (LOCK_COUNT == 1) begin
        state_d = LOCKED;
      end else begin
        state_d = ALIGNED;
      end
    end else begin
      ok_cnt_d = ok_cnt_d;
    end
  end

  // Shift register, bit counter and registered output word/strobes.
  always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      data_valid_q  <= 1'b0;
      comma_det_q   <= 1'b0;
      symbol_lock_q <= 1'b0;
      realign_q     <= 1'b0;
    end else begin
      sr_q <= sr_next_s;
      if (emit_s) begin
        bit_cnt_q <= '0;
        data_q    <= sr_next_s;
      end else begin
        bit_cnt_q <= bit_cnt_q + BC_W'(1'b1);
        data_q    <= data_q;
      end
      data_valid_q  <= emit_s;
      comma_det_q   <= emit_s & comma_match_s;
      symbol_lock_q <= (state_d == LOCKED);
      realign_q     <= realign_s;
    end
  end

  assign Data_Collected = data_q;
  assign Data_Valid     = data_valid_q;
  assign Comma_Det      = comma_det_q;
  assign Symbol_Lock    = symbol_lock_q;
  assign Realign        = realign_q;

`ifdef DESER_ERR_CNT_EN
  logic       mis_locked_s;
  logic       loss_s;
  logic [7:0] err_total_q;

  assign mis_locked_s = (state_q == LOCKED) & misaligned_comma_s;
  assign loss_s       = mis_locked_s & (err_inc_s >= LOSS_CNT_C);

  // Lifetime error count: each misaligned comma in LOCKED plus each lock loss.
  always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_total_q <= 8'h00;
    end else begin
      err_total_q <= sat_add8(err_total_q, {1'b0, mis_locked_s} + {1'b0, loss_s});
    end
  end

  assign Err_Cnt = err_total_q;
`endif

endmodule

// File: tb/tb_comma_align_deserializer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for comma_align_deserializer (default parameters).
// A reference model runs alongside the stimulus and queues the expected
// emission for each edge; the DUT output is popped and compared.
// -----------------------------------------------------------------------------
module tb_comma_align_deserializer;

  localparam logic [9:0] RDN = 10'b0101111100;
  localparam logic [9:0] RDP = 10'b1010000011;
  localparam int LOCK_N = 3;
  localparam int LOSS_N = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ser      = 1'b0;
  logic       rx_pol   = 1'b0;
  logic       align_en = 1'b0;
  logic [9:0] data_collected;
  logic       data_valid;
  logic       comma_det;
  logic       symbol_lock;
  logic       realign;
`ifdef DESER_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  comma_align_deserializer dut (
    .Recovered_Bit_Clk (clk),
    .Rst_n             (rst_n),
    .Ser_in            (ser),
    .RxPolarity        (rx_pol),
    .Align_En          (align_en),
    .Data_Collected    (data_collected),
    .Data_Valid        (data_valid),
    .Comma_Det         (comma_det),
    .Symbol_Lock       (symbol_lock),
    .Realign           (realign)
`ifdef DESER_ERR_CNT_EN
    ,
    .Err_Cnt           (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] word;
    logic       comma;
    logic       realign;
    logic       lock;
    logic [7:0] errcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks     = 0;
  int   n_errors     = 0;
  int   realign_seen = 0;
  int   valid_seen   = 0;

  // Reference model state
  logic [9:0] m_sr;
  int         m_cnt;
  int         m_state;  // 0 unlocked, 1 aligned, 2 locked
  int         m_ok;
  int         m_err;
  int         m_ecnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sr    = 10'd0;
    m_cnt   = 0;
    m_state = 0;
    m_ok    = 0;
    m_err   = 0;
    m_ecnt  = 0;
    exp_q.delete();
    realign_seen = 0;
    valid_seen   = 0;
  endtask

  // Predict what the next rising edge does for line bit 'raw'.
  task automatic model_step(input logic raw);
    logic       s;
    logic [9:0] nxt;
    logic       bnd;
    logic       m;
    logic       rl;
    exp_t       e;
    s   = rx_pol ? ~raw : raw;
    nxt = {s, m_sr[9:1]};
    bnd = (m_cnt == 9);
    m   = (nxt == RDN) || (nxt == RDP);
    rl  = 1'b0;
    if (m_state == 0) begin
      rl = m && align_en;
    end else if (m_state == 1) begin
      if (m && bnd) begin
        m_ok++;
        if (m_ok >= LOCK_N) begin
          m_state = 2;
          m_err   = 0;
        end
      end else if (m && align_en) begin
        rl = 1'b1;
      end
    end else begin
      if (m && bnd) begin
        m_err = 0;
      end else if (m) begin
        m_err++;
        if (m_ecnt < 255) m_ecnt++;
        if (m_err >= LOSS_N) begin
          m_state = 0;
          m_ok    = 0;
          m_err   = 0;
          if (m_ecnt < 255) m_ecnt++;
        end
      end
    end
    if (rl) begin
      m_state = 1;
      m_ok    = 1;
      m_cnt   = 0;
    end else begin
      m_cnt = bnd ? 0 : m_cnt + 1;
    end
    if (bnd || rl) begin
      e.word    = nxt;
      e.comma   = m;
      e.realign = rl;
      e.lock    = (m_state == 2);
      e.errcnt  = m_ecnt[7:0];
      exp_q.push_back(e);
    end
    m_sr = nxt;
  endtask

  // Called at a falling edge: drive one line bit, clock it, check, return at next falling edge.
  task automatic send_bit(input logic b);
    exp_t e;
    logic expv;
    ser = b;
    model_step(b);
    @(posedge clk);
    #1;
    expv = (exp_q.size() != 0);
    check_val("valid", {31'd0, data_valid}, {31'd0, expv});
    if (data_valid) valid_seen++;
    if (realign) realign_seen++;
    if (expv) begin
      e = exp_q.pop_front();
      if (data_valid) begin
        check_val("word", {22'd0, data_collected}, {22'd0, e.word});
        check_val("comma_det", {31'd0, comma_det}, {31'd0, e.comma});
        check_val("realign", {31'd0, realign}, {31'd0, e.realign});
        check_val("lock", {31'd0, symbol_lock}, {31'd0, e.lock});
`ifdef DESER_ERR_CNT_EN
        check_val("err_cnt", {24'd0, err_cnt}, {24'd0, e.errcnt});
`endif
      end
    end else begin
      check_val("idle_realign", {31'd0, realign}, 32'd0);
      check_val("idle_comma", {31'd0, comma_det}, 32'd0);
    end
    @(negedge clk);
  endtask

  // Send a logical word LSB first; on the line it is inverted when rx_pol=1.
  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) begin
      send_bit(rx_pol ? ~w[i] : w[i]);
    end
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(rx_pol ? 1'b1 : 1'b0);
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_valid", {31'd0, data_valid}, 32'd0);
    check_val("rst_data", {22'd0, data_collected}, 32'd0);
    check_val("rst_comma", {31'd0, comma_det}, 32'd0);
    check_val("rst_lock", {31'd0, symbol_lock}, 32'd0);
    check_val("rst_realign", {31'd0, realign}, 32'd0);
`ifdef DESER_ERR_CNT_EN
    check_val("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
  endtask

  initial begin
    // Reset held while the line toggles
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ser = ~ser;
    end
    check_reset_outputs();

    // Free-running cadence with alignment disabled, commas at odd offsets
    model_reset();
    rst_n    = 1'b1;
    align_en = 1'b0;
    send_zeros(20);
    send_zeros(3);
    send_word(RDN);
    send_zeros(7);
    send_word(RDP);
    check_val("noalign_realigns", realign_seen, 0);
    check_val("noalign_valids", valid_seen, 5);
    check_val("noalign_lock", {31'd0, symbol_lock}, 32'd0);

    // Initial alignment on an offset comma
    align_en = 1'b1;
    send_zeros(3);
    send_word(RDN);
    check_val("init_realign_cnt", realign_seen, 1);
    check_val("init_word", {22'd0, data_collected}, {22'd0, RDN});

    // Two more aligned commas reach lock
    send_word(10'd0);
    send_word(RDP);
    check_val("lock_after2", {31'd0, symbol_lock}, 32'd0);
    send_word(10'd0);
    send_word(RDN);
    check_val("lock_after3", {31'd0, symbol_lock}, 32'd1);

    // Comma shifted by two bits: ignored for alignment, lock held
    send_zeros(2);
    send_word(10'd0);
    send_word(RDP);
    check_val("shift_realigns", realign_seen, 1);
    check_val("shift_lock_held", {31'd0, symbol_lock}, 32'd1);

    // Back in phase with an aligned comma, then four misaligned ones
    send_zeros(8);
    send_word(RDN);
    send_zeros(2);
    for (int k = 0; k < 4; k++) begin
      send_word(10'd0);
      send_word((k % 2 == 0) ? RDP : RDN);
      if (k == 2) check_val("loss_held3", {31'd0, symbol_lock}, 32'd1);
    end
    check_val("loss_lock", {31'd0, symbol_lock}, 32'd0);
    check_val("loss_realigns", realign_seen, 1);

    // Next misaligned comma reacquires
    send_word(10'd0);
    send_word(RDP);
    check_val("reacq_realigns", realign_seen, 2);
`ifdef DESER_ERR_CNT_EN
    check_val("err_cnt_total", {24'd0, err_cnt}, 32'd6);
`endif

    // Mid-word reset, then inverted-polarity lock sequence
    send_zeros(4);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ser = ~ser;
    end
    check_reset_outputs();
    model_reset();
    rx_pol = 1'b1;
    rst_n  = 1'b1;
    send_zeros(3);
    send_word(RDN);
    check_val("pol_realign", realign_seen, 1);
    send_word(10'd0);
    send_word(RDP);
    send_word(10'd0);
    send_word(RDN);
    check_val("pol_lock", {31'd0, symbol_lock}, 32'd1);
    check_val("pol_word", {22'd0, data_collected}, {22'd0, RDN});

    check_val("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
